// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake and status bundle for sync_fifo_param.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  clr_err;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, push_data, pop, clr_err,
        input  pop_data, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, clr_err,
        output pop_data, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock show-ahead FIFO with occupancy
// count and almost-full/almost-empty thresholds.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN enables the sticky
// overflow/underflow flags; without it both flags read 0 and clr_err is unused.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  full_w;
    logic                  empty_w;
    logic                  wr;
    logic                  rd;

    // Status is decoded from the count register alone, so every flag moves
    // on the same edge as count and never looks at this cycle's requests.
    assign full_w           = (count_q == DEPTH_C);
    assign empty_w          = (count_q == '0);
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;

    // A push at full is dropped and a pop at empty is ignored; this also
    // resolves simultaneous push/pop at the two extremes.
    assign wr = bus.push & ~full_w;
    assign rd = bus.pop  & ~empty_w;

    // Show-ahead head word straight from the storage array.
    assign bus.pop_data = mem[rptr];

    // Storage write; no reset on the array, reset discards data by clearing pointers.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= bus.push_data;
        end
    end

    // Pointer and occupancy control; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (rd) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr, rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Sticky error capture; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.push & full_w) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (bus.pop & empty_w) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end
`else
    logic unused_clr_err;

    // Error reporting compiled out: flags are constant, clear has no effect.
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
    assign unused_clr_err = bus.clr_err;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param with a data
// scoreboard on the 4-deep instance and threshold walk on a 16-deep instance.
module tb_sync_fifo_param;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   mcnt   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(2)) ia ();
    sync_fifo_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) ib ();

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    sync_fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Scoreboard monitor: every read the DUT accepts must return the oldest expected word.
    always @(negedge clk) begin
        if (!rst && ia.pop && !ia.empty) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected_read: got %0h expected no read", ia.pop_data);
            end else begin
                chk("sb_pop_data", {24'b0, ia.pop_data}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus on instance A; expected words enter the scoreboard here.
    task automatic step(input logic p, input logic [7:0] d, input logic q,
                        input logic c, input logic r);
        bit wr;
        bit rd;
        ia.push = p; ia.push_data = d; ia.pop = q; ia.clr_err = c; rst = r;
        if (r) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            wr = p && (mcnt < 4);
            rd = q && (mcnt > 0);
            if (wr) exp_q.push_back(d);
            mcnt = mcnt + int'(wr) - int'(rd);
        end
        @(posedge clk); #1;
        ia.push = 1'b0; ia.pop = 1'b0; ia.clr_err = 1'b0; rst = 1'b0;
    endtask

    task automatic sa(input string tag, input int cnt, input bit f, input bit e,
                      input bit af, input bit ae);
        chk({tag, "_count"}, {29'b0, ia.count}, cnt);
        chk({tag, "_full"},  {31'b0, ia.full}, {31'b0, f});
        chk({tag, "_empty"}, {31'b0, ia.empty}, {31'b0, e});
        chk({tag, "_afull"}, {31'b0, ia.almost_full}, {31'b0, af});
        chk({tag, "_aempty"}, {31'b0, ia.almost_empty}, {31'b0, ae});
    endtask

    task automatic ea(input string tag, input bit ov, input bit un);
        chk({tag, "_overflow"},  {31'b0, ia.overflow},  {31'b0, ov & ERR});
        chk({tag, "_underflow"}, {31'b0, ia.underflow}, {31'b0, un & ERR});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        ia.push = 1'b0; ia.push_data = '0; ia.pop = 1'b0; ia.clr_err = 1'b0;
        ib.push = 1'b0; ib.push_data = '0; ib.pop = 1'b0; ib.clr_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state on both instances
        sa("reset", 0, 0, 1, 0, 1);
        ea("reset", 0, 0);
        chk("b_reset_count", {27'b0, ib.count}, 0);
        chk("b_reset_empty", {31'b0, ib.empty}, 1);
        chk("b_reset_aempty", {31'b0, ib.almost_empty}, 1);

        // Fill and drain
        step(1, 8'h11, 0, 0, 0); sa("push1", 1, 0, 0, 0, 1);
        chk("show_ahead_head", {24'b0, ia.pop_data}, 32'h11);
        step(1, 8'h22, 0, 0, 0); sa("push2", 2, 0, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0); sa("push3", 3, 0, 0, 1, 0);
        step(1, 8'h44, 0, 0, 0); sa("push4", 4, 1, 0, 1, 0);
        repeat (4) step(0, 8'h00, 1, 0, 0);
        sa("drained", 0, 0, 1, 0, 1);

        // Underflow is sticky and clears on clr_err
        step(0, 8'h00, 1, 0, 0); sa("pop_empty", 0, 0, 1, 0, 1); ea("pop_empty", 0, 1);
        repeat (3) step(0, 8'h00, 0, 0, 0);
        ea("uf_sticky", 0, 1);
        step(0, 8'h00, 0, 1, 0); ea("uf_clr", 0, 0);

        // Wrap-around
        step(1, 8'hA1, 0, 0, 0); step(1, 8'hA2, 0, 0, 0); step(1, 8'hA3, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0); step(0, 8'h00, 1, 0, 0);
        step(1, 8'hA4, 0, 0, 0); step(1, 8'hA5, 0, 0, 0); step(1, 8'hA6, 0, 0, 0);
        sa("wrap_full", 4, 1, 0, 1, 0);

        // Simultaneous push/pop at full: push dropped, read occurs
        step(1, 8'hEE, 1, 0, 0); sa("simul_full", 3, 0, 0, 1, 0); ea("simul_full", 1, 0);
        step(0, 8'h00, 0, 1, 0); ea("ov_clr", 0, 0);
        step(1, 8'hA7, 0, 0, 0); sa("refill", 4, 1, 0, 1, 0);
        // Clear coinciding with a new overflow: set wins
        step(1, 8'hEF, 0, 1, 0); ea("clr_vs_ov", 1, 0); sa("clr_vs_ov", 4, 1, 0, 1, 0);
        step(0, 8'h00, 0, 1, 0); ea("ov_clr2", 0, 0);
        repeat (4) step(0, 8'h00, 1, 0, 0);
        sa("wrap_drained", 0, 0, 1, 0, 1);

        // Simultaneous push/pop mid-occupancy
        step(1, 8'hB1, 0, 0, 0); step(1, 8'hB2, 0, 0, 0);
        step(1, 8'hB3, 1, 0, 0); sa("simul_mid", 2, 0, 0, 0, 0);
        repeat (2) step(0, 8'h00, 1, 0, 0);
        sa("simul_mid_drain", 0, 0, 1, 0, 1);

        // Simultaneous push/pop at empty: only the write happens
        step(1, 8'hC1, 1, 0, 0); sa("simul_empty", 1, 0, 0, 0, 1); ea("simul_empty", 0, 1);
        step(0, 8'h00, 1, 1, 0); sa("simul_empty_drain", 0, 0, 1, 0, 1); ea("simul_empty_clr", 0, 0);

        // Mid-operation reset with a push pending and an error flag set
        step(0, 8'h00, 1, 0, 0);
        step(1, 8'hD1, 0, 0, 0); step(1, 8'hD2, 0, 0, 0); step(1, 8'hD3, 0, 0, 0);
        sa("pre_rst", 3, 0, 0, 1, 0); ea("pre_rst", 0, 1);
        step(1, 8'hD4, 0, 0, 1);
        sa("mid_rst", 0, 0, 1, 0, 1); ea("mid_rst", 0, 0);
        step(1, 8'hE1, 0, 0, 0);
        chk("post_rst_head", {24'b0, ia.pop_data}, 32'hE1);
        step(0, 8'h00, 1, 0, 0); sa("post_rst", 0, 0, 1, 0, 1);
        chk("sb_drained", exp_q.size(), 0);

        // Threshold walk on the 16-deep instance (AF=12, AE=3)
        for (int n = 1; n <= 16; n++) begin
            ib.push = 1'b1; ib.push_data = 16'(32'h1000 + n);
            @(posedge clk); #1;
            ib.push = 1'b0;
            chk("b_fill_count", {27'b0, ib.count}, n);
            chk("b_fill_aempty", {31'b0, ib.almost_empty}, {31'b0, n <= 3});
            chk("b_fill_afull", {31'b0, ib.almost_full}, {31'b0, n >= 12});
            chk("b_fill_full", {31'b0, ib.full}, {31'b0, n == 16});
        end
        ib.push = 1'b1; ib.push_data = 16'hDEAD;
        @(posedge clk); #1;
        ib.push = 1'b0;
        chk("b_drop_count", {27'b0, ib.count}, 16);
        for (int i = 1; i <= 16; i++) begin
            chk("b_drain_data", {16'b0, ib.pop_data}, 32'h1000 + i);
            ib.pop = 1'b1;
            @(posedge clk); #1;
            ib.pop = 1'b0;
            chk("b_drain_aempty", {31'b0, ib.almost_empty}, {31'b0, (16 - i) <= 3});
        end
        chk("b_drain_empty", {31'b0, ib.empty}, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
